// File: rtl/gray_pool_pkg.sv
// gray_pool_pkg: shared types and constants for the 28x28 gray pooling block.
//
// Build option: POOL_MAX_EN selects max pooling (8-bit running maximum per
// column) instead of the default truncated average (16-bit running sum).
package gray_pool_pkg;

    localparam int OUT_DIM    = 28;
    localparam int OUT_PIXELS = OUT_DIM * OUT_DIM;   // 784
    localparam int COL_W      = 5;                   // enough to index OUT_DIM columns

    typedef logic [7:0]       pxl_t;
    typedef logic [9:0]       idx_t;
    typedef logic [COL_W-1:0] col_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

`ifdef POOL_MAX_EN
    localparam int ACC_W = 8;                        // running maximum
`else
    localparam int ACC_W = 16;                       // 255 * 16 * 16 < 2**16
`endif

    typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/pool_acc_bank.sv
// pool_acc_bank: one accumulator per output column of the current block row.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   clear_all_i zero every accumulator (fresh frame)
//   en_i        fold pxl_i into the accumulator selected by col_i
//   emit_i      the folded pixel completes a block: clear that entry
//   col_i       column (block) index, 0..OUT_DIM-1
//   pxl_i       incoming gray pixel
//   result_o    reduced block value including pxl_i (valid when emit_i)
//
// Build option: POOL_MAX_EN -> running maximum, else truncated average.
module pool_acc_bank
    import gray_pool_pkg::*;
#(
    parameter int SHIFT = 8                  // 2*log2(BLK): divide by BLK*BLK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_all_i,
    input  logic       en_i,
    input  logic       emit_i,
    input  logic [4:0] col_i,
    input  logic [7:0] pxl_i,
    output logic [7:0] result_o
);

    acc_t acc_q [OUT_DIM];
    acc_t sel_acc;
    acc_t upd;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        // A fresh frame and its first pixel may arrive together: the pixel
        // must then see a zeroed accumulator, not the aborted frame's sum.
        sel_acc  = clear_all_i ? '0 : acc_q[col_i];
        upd      = sel_acc;
        result_o = '0;
`ifdef POOL_MAX_EN
        upd      = (acc_t'(pxl_i) > sel_acc) ? acc_t'(pxl_i) : sel_acc;
        result_o = upd;
`else
        upd      = sel_acc + acc_t'(pxl_i);
        result_o = pxl_t'(upd >> SHIFT);
`endif
    end

    // NOTE: the accumulator array is reset like any other register because an
    // aborted or reset frame must never leak partial sums into the next one.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
        end else begin
            if (clear_all_i) begin
                for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
            end
            if (en_i) begin
                acc_q[col_i] <= emit_i ? '0 : upd;
            end
        end
    end

endmodule

// File: rtl/gray_pool_28.sv
// gray_pool_28: crops a 28*BLK square window out of the gray pixel stream and
// reduces every BLK x BLK block to one pixel, emitting a 28x28 raster stream.
//
// Ports:
//   CLOCK_50     clock
//   rst_n        asynchronous active-low reset
//   arm          sampled on frame_start; only armed frames are pooled
//   frame_start  frame start pulse (may coincide with pixel (0,0))
//   in_valid     input pixel strobe, in_pxl is the gray pixel
//   out_valid    pooled pixel strobe, out_pxl / out_idx carry value and index
//   frame_done   one-cycle pulse the cycle after output index 783
//   busy         armed frame in progress
//
// Build option: POOL_MAX_EN selects max pooling instead of truncated average.
module gray_pool_28
    import gray_pool_pkg::*;
#(
    parameter int IN_W  = 640,
    parameter int IN_H  = 480,
    parameter int BLK   = 16,
    parameter int X_OFF = 96,
    parameter int Y_OFF = 16
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic [7:0] in_pxl,
    output logic       out_valid,
    output logic [7:0] out_pxl,
    output logic [9:0] out_idx,
    output logic       frame_done,
    output logic       busy
);

    localparam int          X_W      = $clog2(IN_W);
    localparam int          Y_W      = $clog2(IN_H + 1);  // can hold IN_H: "past last line"
    localparam int          LOG2_BLK = $clog2(BLK);
    localparam int          WIN      = OUT_DIM * BLK;
    localparam logic [31:0] BLK_MASK = 32'(BLK - 1);

    state_e         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    idx_t           idx_q, idx_d;
    logic           out_valid_q, out_valid_d;
    pxl_t           out_pxl_q, out_pxl_d;
    idx_t           out_idx_q, out_idx_d;
    logic           frame_done_q, frame_done_d;

    logic           start, pix_en, live_line, in_win, blk_end, acc_en, emit, last_out;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic [31:0]    wx, wy;
    col_t           col;
    idx_t           idx_base;
    pxl_t           acc_result;

    // Pixel position and window decode.
    always_comb begin
        start     = frame_start && arm;
        // A frame_start in RUN without arm aborts; its pixel is not pooled.
        pix_en    = in_valid && (start || (state_q == RUN && !frame_start));
        cur_x     = start ? '0 : x_q;
        cur_y     = start ? '0 : y_q;
        wx        = 32'(cur_x) - 32'(X_OFF);
        wy        = 32'(cur_y) - 32'(Y_OFF);
        live_line = 32'(cur_y) < 32'(IN_H);
        // Left of / above the window the subtraction wraps to a huge value,
        // so one unsigned upper-bound compare covers both window edges.
        in_win    = (wx < 32'(WIN)) && (wy < 32'(WIN));
        blk_end   = ((wx & BLK_MASK) == BLK_MASK) && ((wy & BLK_MASK) == BLK_MASK);
        acc_en    = pix_en && live_line && in_win;
        emit      = acc_en && blk_end;
        col       = col_t'(wx >> LOG2_BLK);
        idx_base  = start ? '0 : idx_q;
        last_out  = out_valid_q && (out_idx_q == idx_t'(OUT_PIXELS - 1));
    end

    pool_acc_bank #(
        .SHIFT (2 * LOG2_BLK)
    ) u_acc (
        .clk         (CLOCK_50),
        .rst_n       (rst_n),
        .clear_all_i (start),
        .en_i        (acc_en),
        .emit_i      (emit),
        .col_i       (col),
        .pxl_i       (in_pxl),
        .result_o    (acc_result)
    );

    // FSM, counters and output next-state.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        idx_d        = idx_q;
        out_valid_d  = emit;
        out_pxl_d    = out_pxl_q;
        out_idx_d    = out_idx_q;

        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (frame_start) begin
                    state_d = arm ? RUN : IDLE;
                end else if (last_out) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            x_d       = '0;
            y_d       = '0;
            idx_d     = '0;
            out_idx_d = '0;
        end

        // Lines past IN_H freeze the counters, so extra pixels are ignored.
        if (pix_en && live_line) begin
            if (cur_x == X_W'(IN_W - 1)) begin
                x_d = '0;
                y_d = cur_y + Y_W'(1);
            end else begin
                x_d = cur_x + X_W'(1);
            end
        end

        if (emit) begin
            out_pxl_d = acc_result;
            out_idx_d = idx_base;
            idx_d     = idx_base + idx_t'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_pxl_q    <= '0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_pxl_q    <= out_pxl_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pxl    = out_pxl_q;
    assign out_idx    = out_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_gray_pool_28.sv
// tb_gray_pool_28: scoreboard bench for gray_pool_28 on a reduced frame
// (64x60, 2x2 blocks, window at (5,3)) so several frames fit in a short run.
// Expected block values are computed from the pixel pattern itself and
// queued when the block's last pixel is driven; a monitor pops and compares.
module tb_gray_pool_28;

    localparam int IN_W  = 64;
    localparam int IN_H  = 60;
    localparam int BLK   = 2;
    localparam int X_OFF = 5;
    localparam int Y_OFF = 3;
    localparam int DIM   = 28;

    typedef enum int {PM_CONST, PM_RAMP, PM_WIN, PM_SINGLE, PM_RAND} pmode_e;

    typedef struct {
        logic [9:0] idx;
        logic [7:0] pxl;
        int         cyc;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       arm;
    logic       frame_start;
    logic       in_valid;
    logic [7:0] in_pxl;
    logic       out_valid;
    logic [7:0] out_pxl;
    logic [9:0] out_idx;
    logic       frame_done;
    logic       busy;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   last_cyc  = -100;
    int   busy_hits = 0;

    gray_pool_28 #(
        .IN_W (IN_W), .IN_H (IN_H), .BLK (BLK), .X_OFF (X_OFF), .Y_OFF (Y_OFF)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .arm         (arm),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_pxl      (in_pxl),
        .out_valid   (out_valid),
        .out_pxl     (out_pxl),
        .out_idx     (out_idx),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_window(input int x, input int y);
        return (x >= X_OFF) && (x < X_OFF + DIM * BLK) && (y >= Y_OFF) && (y < Y_OFF + DIM * BLK);
    endfunction

    function automatic logic [7:0] pix(input pmode_e m, input int x, input int y);
        case (m)
            PM_CONST:  return 8'h80;
            PM_RAMP:   return 8'(x);
            PM_WIN:    return in_window(x, y) ? 8'h00 : 8'hFF;
            PM_SINGLE: return (x == X_OFF && y == Y_OFF) ? 8'hFF : 8'h00;
            default:   return 8'((x * 29 + y * 113 + x * y * 7 + 17) ^ (y << 3));
        endcase
    endfunction

    function automatic logic [7:0] blk_exp(input pmode_e m, input int bx, input int by);
        int sum = 0;
        int mx  = 0;
        for (int j = 0; j < BLK; j++) begin
            for (int i = 0; i < BLK; i++) begin
                int p;
                p = int'(pix(m, X_OFF + bx * BLK + i, Y_OFF + by * BLK + j));
                sum += p;
                if (p > mx) mx = p;
            end
        end
`ifdef POOL_MAX_EN
        return 8'(mx);
`else
        return 8'(sum / (BLK * BLK));
`endif
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLOCK_50) begin
        exp_t m;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                m = exp_q.pop_front();
                check("out_idx", 32'(out_idx), 32'(m.idx));
                check("out_pxl", 32'(out_pxl), 32'(m.pxl));
                check("out_latency", 32'(cyc), 32'(m.cyc + 1));
                if (m.idx == 10'd783) last_cyc = cyc;
            end
        end
        if (rst_n && frame_done) begin
            done_cnt++;
            check("done_latency", 32'(cyc), 32'(last_cyc + 1));
        end
    end

    // Drives one frame with random in_valid gaps; stop_pushes > 0 stops the
    // frame right after that many blocks have been completed.
    task automatic drive_frame(input pmode_e mode, input logic arm_v,
                               input bit fs_with_pix, input int stop_pushes);
        int   pushed;
        bit   first;
        exp_t e;
        pushed      = 0;
        busy_hits   = 0;
        first       = 1'b1;
        arm         = arm_v;
        frame_start = 1'b1;
        if (!fs_with_pix) begin
            in_valid = 1'b0;
            @(posedge CLOCK_50); #1;
            frame_start = 1'b0;
            check("busy_start", 32'(busy), 32'(arm_v));
            first = 1'b0;
            arm   = 1'($urandom_range(0, 1));
        end
        for (int y = 0; y < IN_H; y++) begin
            for (int x = 0; x < IN_W; x++) begin
                while (!frame_start && $urandom_range(0, 15) == 0) begin
                    in_valid = 1'b0;
                    @(posedge CLOCK_50); #1;
                    if (busy) busy_hits++;
                end
                in_valid = 1'b1;
                in_pxl   = pix(mode, x, y);
                if (arm_v && in_window(x, y) &&
                    ((x - X_OFF) % BLK == BLK - 1) && ((y - Y_OFF) % BLK == BLK - 1)) begin
                    e.idx = 10'(((y - Y_OFF) / BLK) * DIM + (x - X_OFF) / BLK);
                    e.pxl = blk_exp(mode, (x - X_OFF) / BLK, (y - Y_OFF) / BLK);
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    pushed++;
                end
                @(posedge CLOCK_50); #1;
                in_valid    = 1'b0;
                frame_start = 1'b0;
                if (busy) busy_hits++;
                if (first) begin
                    check("busy_start", 32'(busy), 32'(arm_v));
                    first = 1'b0;
                    arm   = 1'($urandom_range(0, 1));
                end
                if (stop_pushes > 0 && pushed >= stop_pushes) return;
            end
        end
    endtask

    task automatic finish_frame(input int exp_done);
        repeat (6) @(posedge CLOCK_50);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("busy_after", 32'(busy), 32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        arm         = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_pxl      = 8'h00;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_pxl", 32'(out_pxl), 32'(0));
        check("rst_out_idx", 32'(out_idx), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(posedge CLOCK_50); #1;

        drive_frame(PM_CONST, 1'b1, 1'b0, 0);  finish_frame(1);
        drive_frame(PM_RAMP, 1'b1, 1'b1, 0);   finish_frame(2);
        drive_frame(PM_WIN, 1'b1, 1'b0, 0);    finish_frame(3);
        drive_frame(PM_SINGLE, 1'b1, 1'b1, 0); finish_frame(4);
        drive_frame(PM_RAND, 1'b1, 1'b0, 0);   finish_frame(5);

        // Armed restart after 300 outputs: no frame_done for the aborted frame.
        drive_frame(PM_RAND, 1'b1, 1'b1, 300);
        drive_frame(PM_CONST, 1'b1, 1'b1, 0);  finish_frame(6);

        // Unarmed frame_start aborts a running frame; the frame is not pooled.
        drive_frame(PM_RAND, 1'b1, 1'b0, 50);
        drive_frame(PM_RAMP, 1'b0, 1'b1, 0);
        check("busy_unarmed", 32'(busy_hits), 32'(0));
        finish_frame(6);

        // Reset in mid-frame: outputs drop at once, nothing until re-armed.
        drive_frame(PM_RAND, 1'b1, 1'b0, 100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_pxl", 32'(out_pxl), 32'(0));
        check("midrst_out_idx", 32'(out_idx), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge CLOCK_50);
        #1;
        rst_n     = 1'b1;
        busy_hits = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_pxl   = 8'($urandom_range(0, 255));
            @(posedge CLOCK_50); #1;
            if (busy) busy_hits++;
        end
        in_valid = 1'b0;
        check("busy_after_reset", 32'(busy_hits), 32'(0));
        drive_frame(PM_RAMP, 1'b1, 1'b0, 0);   finish_frame(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_pool_28.md
# gray_pool_28

Spatial down-sampler between the Bayer-to-gray converter and the DMEM pixel packer. It consumes the 8-bit normalised gray pixel stream, crops a square window, and reduces each BLK×BLK block to one pixel. Output is a 28×28 raster stream (784 pixels, row-major) with an index, one output per input cycle, ready for 16-pixel word packing.

## Interface
Parameters:
- IN_W, 640: input line length in pixels.
- IN_H, 480: input lines per frame.
- BLK, 16: block edge in pixels; must be a power of two, ≤16.
- X_OFF, 96: first window column; X_OFF + 28·BLK ≤ IN_W.
- Y_OFF, 16: first window line; Y_OFF + 28·BLK ≤ IN_H.

Ports:
- CLOCK_50 in 1: sole clock.
- rst_n in 1: asynchronous, active-low reset.
- arm in 1: sampled at frame_start; a frame is pooled only if arm=1 then.
- frame_start in 1: one-cycle pulse, first pixel of a frame follows or coincides.
- in_valid in 1: one-cycle pixel strobe.
- in_pxl in 8: gray pixel, valid with in_valid.
- out_valid out 1: pooled pixel strobe.
- out_pxl out 8: pooled pixel.
- out_idx out 10: raster index of out_pxl, 0..783.
- frame_done out 1: one-cycle pulse after the 784th output.
- busy out 1: high from an armed frame_start until frame_done or abort.

## Operation
- States: IDLE, RUN. IDLE→RUN on frame_start with arm=1. RUN→IDLE one cycle after out_idx=783 is emitted (frame_done asserted on that cycle). frame_start in RUN: abort, restart as a fresh frame if arm=1, otherwise go to IDLE. No frame_done is issued for an aborted frame.
- Counters x (0..IN_W-1) and y (0..IN_H-1) advance on in_valid in RUN. x wraps to 0 and y increments. Pixels beyond IN_H lines are ignored.
- frame_start with in_valid in the same cycle: that pixel is (0,0) of the new frame.
- In-window test: X_OFF ≤ x < X_OFF+28·BLK and Y_OFF ≤ y < Y_OFF+28·BLK. Out-of-window pixels are ignored.
- Column accumulators: 28 × 16-bit sums, indexed by (x−X_OFF)/BLK. An in-window pixel adds to its column.
- Emission: on the pixel at the last column and last line of a block, out_pxl = (acc + in_pxl) >> (2·log2 BLK), truncating. The accumulator clears in the same cycle.
- out_idx increments after each emission. It resets to 0 on an armed frame_start.
- Sum width: 255·BLK² < 2¹⁶, so there is no overflow.
- Reset values: all outputs 0, state IDLE, counters and accumulators 0.

## Timing
- Latency: out_valid is registered and occurs 1 cycle after the completing in_valid. frame_done occurs 1 cycle after the last out_valid.
- Throughput: one output per cycle maximum. There is no back-pressure; the consumer must accept every out_valid.
- Reset asserted mid-frame: outputs drop to 0 immediately, and no further outputs occur until the next armed frame_start.
- arm changes mid-frame: ignored until the next frame_start.

## Configuration
- POOL_MAX_EN defined: each block reduces to its maximum. Accumulators hold an 8-bit running max; out_pxl = max(acc, in_pxl); each accumulator clears to 0.
- POOL_MAX_EN undefined: truncated average, as described in Operation.

## Structure
- Package gray_pool_pkg:
  - OUT_DIM=28 and OUT_PIXELS=784.
  - pxl_t (8-bit) and idx_t (10-bit) typedefs.
  - State enum {IDLE, RUN}.
- Sub-module pool_acc_bank: the 28-entry accumulator array with add/clear/read, selected by POOL_MAX_EN.
- Top level holds the counters, window decode, FSM and output registers.

## Test plan
- Constant 0x80 frame, 640×480, armed: exactly 784 out_valid with out_pxl=0x80 and out_idx 0..783 in order. One frame_done, 1 cycle after idx 783.
- in_pxl = x[7:0]: idx 0 gives 0x67 (mean of 96..111, truncated) and idx 1 gives 0x77. Every row repeats the same 28-value sequence.
- Pixels outside the window are 0xFF and inside are 0x00: all 784 outputs are 0x00.
- Single 0xFF at (96,16), rest 0: idx 0 gives 0x00 by default and 0xFF with POOL_MAX_EN. All other outputs are 0x00.
- frame_start after 300 outputs: out_idx restarts at 0 and no frame_done for the aborted frame. The following full frame gives 784 outputs and one frame_done.
- arm=0 at frame_start: no out_valid and busy stays 0. rst_n pulsed low mid-frame: outputs 0 at once, and no output until the next armed frame.
